// File: rtl/matmul2x2_seq_core.sv
// matmul2x2_seq_core: sequential 2x2 unsigned matrix multiplier.
// Four operand bytes are loaded over a valid/ready stream. C = A*B is then
// computed with one shared multiply-accumulate unit. The four results are
// streamed out in order C00, C01, C10, C11, each with its index.
module matmul2x2_seq_core #(
    parameter int unsigned ELEM_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*ELEM_W-1:0]   in_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*ELEM_W:0]     res_data,
    output logic [1:0]            res_idx,
    output logic                  busy
);

    localparam int unsigned PW    = 2 * ELEM_W;
    localparam int unsigned ACC_W = 2 * ELEM_W + 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC0 = 2'd1,
        MAC1 = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [1:0]         idx_q;
    logic [ACC_W-1:0]   acc_q;
    logic               res_valid_q;
    // Element k of A is A_{k[1],k[0]}; the same holds for B.
    logic [ELEM_W-1:0]  a_q [4];
    logic [ELEM_W-1:0]  b_q [4];

    logic [ELEM_W-1:0]  mul_a_d;
    logic [ELEM_W-1:0]  mul_b_d;
    logic [PW-1:0]      prod_d;
    logic               k_d;

    // Shared multiplier: pick the A_ik * B_kj term for the current MAC step.
    always_comb begin
        k_d     = (state_q == MAC1);
        mul_a_d = a_q[{idx_q[1], k_d}];
        mul_b_d = b_q[{k_d, idx_q[0]}];
        prod_d  = PW'(mul_a_d) * PW'(mul_b_d);
    end

    // Control FSM, operand capture, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (!cnt_q[1]) begin
                            a_q[{cnt_q[0], 1'b0}] <= in_data[ELEM_W-1:0];
                            a_q[{cnt_q[0], 1'b1}] <= in_data[PW-1:ELEM_W];
                        end else begin
                            b_q[{cnt_q[0], 1'b0}] <= in_data[ELEM_W-1:0];
                            b_q[{cnt_q[0], 1'b1}] <= in_data[PW-1:ELEM_W];
                        end
                        // Count wraps to 0 after byte3.
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            idx_q   <= '0;
                            state_q <= MAC0;
                        end
                    end
                end
                MAC0: begin
                    acc_q   <= ACC_W'(prod_d);
                    state_q <= MAC1;
                end
                MAC1: begin
                    acc_q       <= acc_q + ACC_W'(prod_d);
                    res_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (idx_q == 2'd3) begin
                            state_q <= LOAD;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= MAC0;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD) && !rst;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_idx   = idx_q;
    assign busy      = (cnt_q != 2'd0) || (state_q != LOAD);

endmodule

// File: tb/tb_matmul2x2_seq_core.sv
// Scoreboard bench for matmul2x2_seq_core. The driver pushes the expected
// results for each transaction. A negedge monitor pops and compares them.
module tb_matmul2x2_seq_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_data;
    logic [1:0] res_idx;
    logic       busy;

    always #5 clk = ~clk;

    matmul2x2_seq_core #(.ELEM_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .busy      (busy)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [8:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ev_cyc = 0;
    bit   tm_ok = 0;
    int   rr_mode = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain matrix product from the four bytes.
    function automatic void push_expected(input logic [7:0] b[4]);
        int   a[2][2];
        int   m[2][2];
        exp_t e;
        a[0][0] = int'(b[0][3:0]); a[0][1] = int'(b[0][7:4]);
        a[1][0] = int'(b[1][3:0]); a[1][1] = int'(b[1][7:4]);
        m[0][0] = int'(b[2][3:0]); m[0][1] = int'(b[2][7:4]);
        m[1][0] = int'(b[3][3:0]); m[1][1] = int'(b[3][7:4]);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                e.idx  = 2'(2 * i + j);
                e.data = 9'(a[i][0] * m[0][j] + a[i][1] * m[1][j]);
                sb.push_back(e);
            end
    endfunction

    // Monitor: compare presented results against the scoreboard head.
    bit prev_v = 0;
    bit hs_prev = 0;
    bit chk_ir = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 0;
            hs_prev = 0;
            chk_ir  = 0;
        end else begin
            if (chk_ir) begin
                check("in_ready_after_C11", in_ready, 1);
                chk_ir = 0;
            end
            if (prev_v && !res_valid)
                check("valid_drop_needs_handshake", hs_prev, 1);
            if (res_valid) begin
                if (!prev_v && tm_ok)
                    check("res_valid_latency", cyc - ev_cyc, 3);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got idx=%0d data=%0d, none expected", res_idx, res_data);
                end else begin
                    check("res_idx", res_idx, sb[0].idx);
                    check("res_data", res_data, sb[0].data);
                    if (res_ready) begin
                        if (sb[0].idx == 2'd3) begin
                            chk_ir = 1;
                            tm_ok  = 0;
                        end
                        void'(sb.pop_front());
                        ev_cyc = cyc;
                    end
                end
            end
            hs_prev = res_valid && res_ready;
            prev_v  = res_valid;
        end
    end

    // res_ready pattern: 0 always high, 1 five stall cycles per result, 2 random.
    initial begin
        int hold = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: res_ready = 1'b1;
                1: begin
                    if (res_valid && hold < 5) begin
                        res_ready = 1'b0;
                        hold++;
                    end else begin
                        res_ready = res_valid;
                        hold = 0;
                    end
                end
                default: res_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 300 cycles");
            in_valid = 1'b0;
            ok = 0;
            return;
        end
        if (last) begin
            ev_cyc = cyc;
            tm_ok  = 1;
        end
        ok = 1;
        tick();
        in_valid = 1'b0;
        check("busy_after_byte", busy, 1);
    endtask

    task automatic send_txn(input logic [7:0] b[4], input int max_gap, input bit junk);
        bit ok;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(b[k], k == 3, ok);
            if (!ok) return;
        end
        push_expected(b);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            repeat (6) tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        tick();
        tick();
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_idx", res_idx, 0);
        sb.delete();
        tm_ok = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] basic[4];
        logic [7:0] maxv[4];
        logic [7:0] other[4];
        logic [7:0] rb[4];
        bit ok;
        int n;
        basic = '{8'h21, 8'h43, 8'h65, 8'h87};
        maxv  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        other = '{8'h9E, 8'h3C, 8'h71, 8'hD5};

        do_reset();

        // Basic, max values, backpressure, gaps, ignored input
        send_txn(basic, 0, 0); wait_drain();
        send_txn(maxv, 0, 0);  wait_drain();
        rr_mode = 1;
        send_txn(basic, 0, 0); wait_drain();
        rr_mode = 0;
        send_txn(basic, 3, 0); wait_drain();
        send_txn(basic, 0, 1); wait_drain();

        // Reset after byte1, then a clean transaction
        send_byte(8'h5A, 0, ok);
        send_byte(8'hC3, 0, ok);
        do_reset();
        send_txn(basic, 0, 0); wait_drain();

        // Reset while presenting C01
        rr_mode = 1;
        send_txn(other, 0, 0);
        n = 0;
        while (!(res_valid && res_idx == 2'd1) && n < 200) begin
            tick();
            n++;
        end
        check("reached_out_idx1", res_idx, 1);
        do_reset();
        rr_mode = 0;
        send_txn(maxv, 0, 0); wait_drain();

        // Back-to-back: second byte0 waits with valid held high
        send_txn(basic, 0, 0);
        send_txn(other, 0, 0);
        wait_drain();

        // Randomized transactions
        repeat (25) begin
            rr_mode = int'($urandom_range(2, 0));
            for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
            send_txn(rb, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 1) wait_drain();
        end
        rr_mode = 0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
